// File: rtl/load_store_unit_if.sv
// Execute-side request/response signals plus the doubleword memory port of the load/store unit.
interface load_store_unit_if #(
  parameter int BITS      = 64,
  parameter int ADDR_BITS = 8
);
  logic                 req;
  logic                 write;
  logic [2:0]           funct3;
  logic [ADDR_BITS-1:0] addr;
  logic [BITS-1:0]      wdata;
  logic                 ready;
  logic                 done;
  logic                 misaligned;
  logic [BITS-1:0]      rdata;
  logic [ADDR_BITS-4:0] mem_addr;
  logic                 mem_we;
  logic [BITS-1:0]      mem_din;
  logic [BITS-1:0]      mem_dout;

  // Handshake: a request is taken on a rising edge where req=1 and ready=1;
  // done pulses for one cycle when it completes, misaligned qualifies done.
  modport master (
    output req, write, funct3, addr, wdata, mem_dout,
    input  ready, done, misaligned, rdata, mem_addr, mem_we, mem_din
  );

  modport slave (
    input  req, write, funct3, addr, wdata, mem_dout,
    output ready, done, misaligned, rdata, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/load_store_unit.sv
// Sequences byte-addressed loads/stores onto a word-addressed 64-bit memory,
// extending load lanes and read-modify-writing partial stores.
module load_store_unit #(
  parameter int BITS      = 64,
  parameter int DEPTH     = 32,
  parameter int ADDR_BITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus,
  output logic [1:0]         fsm_state
);
  localparam int IDX_BITS = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;
  state_t state, state_nxt;

  logic                 lat_write;
  logic [2:0]           lat_funct3;
  logic [ADDR_BITS-1:0] lat_addr;
  logic [BITS-1:0]      lat_wdata;
  logic                 lat_err;
  logic [BITS-1:0]      buffer;
  logic [BITS-1:0]      rdata_q;
  logic                 done_q;
  logic                 misaligned_q;

  logic                 req_err;
  logic [5:0]           shamt;
  logic [BITS-1:0]      lane;
  logic [BITS-1:0]      load_ext;
  logic [7:0]           byte_mask;
  logic [BITS-1:0]      bit_mask;
  logic [BITS-1:0]      wdata_sh;

  // Alignment and encoding checks on the live request, sampled only when accepted.
  always_comb begin
    req_err = 1'b0;
    case (bus.funct3[1:0])
      2'b01:   req_err = bus.addr[0];
      2'b10:   req_err = |bus.addr[1:0];
      2'b11:   req_err = |bus.addr[2:0];
      default: req_err = 1'b0;
    endcase
    if (bus.funct3 == 3'b111 || (bus.funct3[2] && bus.write)) req_err = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req) state_nxt = req_err ? RESP : READ;
      READ:    state_nxt = lat_write ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mem_we is decoded straight from state so a mid-write reset removes it at once.
  always_comb begin
    bus.ready  = (state == IDLE);
    bus.mem_we = (state == WRITE);
    fsm_state  = state;
  end

  // Load path: shift the addressed lane down, then extend by access size.
  always_comb begin
    shamt    = {lat_addr[2:0], 3'b000};
    lane     = bus.mem_dout >> shamt;
    load_ext = lane;
    case (lat_funct3[1:0])
      2'b00:   load_ext = {{(BITS-8){~lat_funct3[2] & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{(BITS-16){~lat_funct3[2] & lane[15]}}, lane[15:0]};
      2'b10:   load_ext = {{(BITS-32){~lat_funct3[2] & lane[31]}}, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  // Store path: replace only the addressed bytes of the buffered doubleword.
  always_comb begin
    case (lat_funct3[1:0])
      2'b00:   byte_mask = 8'h01;
      2'b01:   byte_mask = 8'h03;
      2'b10:   byte_mask = 8'h0f;
      default: byte_mask = 8'hff;
    endcase
    byte_mask = byte_mask << lat_addr[2:0];
    bit_mask  = '0;
    for (int i = 0; i < 8; i++) bit_mask[i*8 +: 8] = {8{byte_mask[i]}};
    wdata_sh    = lat_wdata << shamt;
    bus.mem_din = (buffer & ~bit_mask) | (wdata_sh & bit_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_write    <= 1'b0;
      lat_funct3   <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_err      <= 1'b0;
      buffer       <= '0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      case (state)
        IDLE: if (bus.req) begin
          lat_write  <= bus.write;
          lat_funct3 <= bus.funct3;
          lat_addr   <= bus.addr;
          lat_wdata  <= bus.wdata;
          lat_err    <= req_err;
        end
        READ: begin
          buffer <= bus.mem_dout;
          if (!lat_write) rdata_q <= load_ext;
        end
        RESP: begin
          done_q       <= 1'b1;
          misaligned_q <= lat_err;
          if (lat_err) rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr   = lat_addr[3 +: IDX_BITS];
  assign bus.rdata      = rdata_q;
  assign bus.done       = done_q;
  assign bus.misaligned = misaligned_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 32x64 memory.
module tb_load_store_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] fsm_state;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int we_cnt = 0;

  logic [63:0] mem [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = '0;
  logic [63:0] pl_val = '0;

  load_store_unit_if #(.BITS(64), .ADDR_BITS(8)) bus ();

  load_store_unit #(.BITS(64), .DEPTH(32), .ADDR_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  assign bus.mem_dout = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (pl_en)           mem[pl_idx] <= pl_val;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    if (bus.done)   done_cnt <= done_cnt + 1;
    if (bus.mem_we) we_cnt   <= we_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] idx, input logic [63:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issues one request from IDLE; lat = cycles from accept edge to done, 0 on timeout.
  task automatic do_op(input logic w, input logic [2:0] f3, input logic [7:0] a,
                       input logic [63:0] wd, output int lat);
    bus.req = 1'b1; bus.write = w; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.write = 1'b1; bus.funct3 = 3'b111; bus.addr = '1; bus.wdata = '1;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int we0;
    int d0;
    reset = 1'b1;
    bus.req = 1'b0; bus.write = 1'b0; bus.funct3 = '0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < 32; i++) preload(5'(i), 64'd0);
    #1;
    check("rst_ready", {63'd0, bus.ready}, 64'd1);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_misaligned", {63'd0, bus.misaligned}, 64'd0);
    check("rst_rdata", bus.rdata, 64'd0);
    check("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
    check("rst_mem_addr", {59'd0, bus.mem_addr}, 64'd0);
    check("rst_mem_din", bus.mem_din, 64'd0);
    check("rst_state", {62'd0, fsm_state}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Plain doubleword load
    preload(5'd6, 64'd51);
    we0 = we_cnt;
    do_op(1'b0, 3'b011, 8'h30, 64'd0, lat);
    check("ld_latency", 64'(lat), 64'd2);
    check("ld_rdata", bus.rdata, 64'd51);
    check("ld_misaligned", {63'd0, bus.misaligned}, 64'd0);
    check("ld_no_we", 64'(we_cnt - we0), 64'd0);
    check("ld_ready_after", {63'd0, bus.ready}, 64'd1);

    // Byte store into byte 1 of mem[6], then signed and unsigned byte loads
    preload(5'd6, 64'h33);
    we0 = we_cnt;
    do_op(1'b1, 3'b000, 8'h31, 64'hAB, lat);
    check("sb_latency", 64'(lat), 64'd3);
    check("sb_we_once", 64'(we_cnt - we0), 64'd1);
    check("sb_mem6", mem[6], 64'hAB33);
    do_op(1'b0, 3'b000, 8'h31, 64'd0, lat);
    check("lb_rdata", bus.rdata, 64'hFFFF_FFFF_FFFF_FFAB);
    do_op(1'b0, 3'b100, 8'h31, 64'd0, lat);
    check("lbu_rdata", bus.rdata, 64'hAB);

    // Word store to upper half, then signed/unsigned word loads
    preload(5'd2, 64'd94);
    do_op(1'b1, 3'b010, 8'h14, 64'hDEADBEEF, lat);
    check("sw_mem2", mem[2], 64'hDEADBEEF_0000005E);
    do_op(1'b0, 3'b010, 8'h14, 64'd0, lat);
    check("lw_rdata", bus.rdata, 64'hFFFF_FFFF_DEAD_BEEF);
    do_op(1'b0, 3'b110, 8'h14, 64'd0, lat);
    check("lwu_rdata", bus.rdata, 64'h0000_0000_DEAD_BEEF);

    // Full doubleword store, then halfword/byte lanes from it
    do_op(1'b1, 3'b011, 8'h08, 64'h0123_4567_89AB_CDEF, lat);
    check("sd_mem1", mem[1], 64'h0123_4567_89AB_CDEF);
    do_op(1'b0, 3'b001, 8'h0C, 64'd0, lat);
    check("lh_rdata", bus.rdata, 64'h4567);
    do_op(1'b0, 3'b101, 8'h0E, 64'd0, lat);
    check("lhu_rdata", bus.rdata, 64'h0123);
    do_op(1'b0, 3'b000, 8'h0B, 64'd0, lat);
    check("lb_neg_rdata", bus.rdata, 64'hFFFF_FFFF_FFFF_FF89);

    // Rejected requests
    we0 = we_cnt;
    do_op(1'b0, 3'b010, 8'h12, 64'd0, lat);
    check("lw_mis_latency", 64'(lat), 64'd1);
    check("lw_mis_flag", {63'd0, bus.misaligned}, 64'd1);
    check("lw_mis_rdata", bus.rdata, 64'd0);
    do_op(1'b1, 3'b100, 8'h30, 64'hFFFF, lat);
    check("sd_f100_latency", 64'(lat), 64'd1);
    check("sd_f100_flag", {63'd0, bus.misaligned}, 64'd1);
    check("sd_f100_rdata", bus.rdata, 64'd0);
    check("sd_f100_mem6", mem[6], 64'hAB33);
    do_op(1'b0, 3'b001, 8'h31, 64'd0, lat);
    check("lh_mis_flag", {63'd0, bus.misaligned}, 64'd1);
    do_op(1'b0, 3'b111, 8'h00, 64'd0, lat);
    check("f111_flag", {63'd0, bus.misaligned}, 64'd1);
    check("rejects_no_we", 64'(we_cnt - we0), 64'd0);

    // Reset during the WRITE cycle of a halfword store
    preload(5'd5, 64'd18);
    d0 = done_cnt;
    bus.req = 1'b1; bus.write = 1'b1; bus.funct3 = 3'b001; bus.addr = 8'h28; bus.wdata = 64'hBEEF;
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(posedge clk); #1;
    check("sh_in_write", {62'd0, fsm_state}, 64'd2);
    check("sh_we_before_rst", {63'd0, bus.mem_we}, 64'd1);
    reset = 1'b1;
    #1;
    check("sh_we_async_drop", {63'd0, bus.mem_we}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mem5_kept", mem[5], 64'd18);
    check("rst_ready_after", {63'd0, bus.ready}, 64'd1);
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);

    // req held high across several transactions
    d0 = done_cnt;
    bus.req = 1'b1; bus.write = 1'b0; bus.funct3 = 3'b011; bus.addr = 8'h30; bus.wdata = '0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      check($sformatf("held_ready_%0d", k), {63'd0, bus.ready}, (k % 3 == 2) ? 64'd1 : 64'd0);
    end
    bus.req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("held_done_count", 64'(done_cnt - d0), 64'd3);
    check("held_rdata", bus.rdata, 64'hAB33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
